// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and access-size helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  // One bit per byte touched by the access; size 3 behaves as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'h1;
      SZ_HALF: m = 4'h3;
      SZ_WORD: m = 4'hF;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte-lane masks, store-data shifts per beat,
// and load-data merge plus sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  input  logic [31:0] rd_acc,
  input  logic        second_beat,
  output logic [7:0]  lane_mask,
  output logic        split,
  output logic [31:0] st_beat0,
  output logic [31:0] st_beat1,
  output logic [31:0] rd_raw,
  output logic [31:0] rd_ext
);

  logic [5:0] sh0;
  logic [5:0] sh1;

  always_comb begin
    sh0       = 6'({off, 3'b000});
    sh1       = 6'd32 - sh0;
    lane_mask = 8'(byte_mask(size)) << off;
    split     = |lane_mask[7:4];
    st_beat0  = st_data << sh0;
    st_beat1  = st_data >> sh1;

    // The second beat supplies the upper bytes that spilled past the word.
    if (second_beat) begin
      rd_raw = rd_acc | (rd_data << sh1);
    end else begin
      rd_raw = rd_data >> sh0;
    end

    case (size)
      SZ_BYTE: rd_ext = {{24{sign_ext & rd_raw[7]}}, rd_raw[7:0]};
      SZ_HALF: rd_ext = {{16{sign_ext & rd_raw[15]}}, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execution-unit request into one or two Wishbone
// classic beats and returns load results as a register-file write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 64
) (
  input  logic                        wb_clk_i,
  input  logic                        rst,
  input  logic                        is_load,
  input  logic                        is_store,
  input  logic [31:0]                 address,
  input  logic [1:0]                  loadstore_size,
  input  logic                        sign_extend,
  input  logic [$clog2(NUM_REGS)-1:0] loadstore_dest,
  input  logic [31:0]                 store_data,
  output logic                        busy,
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [31:0]                 wbm_adr_o,
  output logic [3:0]                  wbm_sel_o,
  output logic [31:0]                 wbm_dat_o,
  input  logic [31:0]                 wbm_dat_i,
  input  logic                        wbm_ack_i,
  output logic                        ld_valid,
  output logic [$clog2(NUM_REGS)-1:0] ld_idx,
  output logic [31:0]                 ld_val,
  output logic [1:0]                  ld_mask
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  lsu_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             store_q, store_d;
  logic [31:0]      acc_q, acc_d;

  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      dato_q, dato_d;
  logic             ldv_q, ldv_d;
  logic [IDX_W-1:0] ldidx_q, ldidx_d;
  logic [31:0]      ldval_q, ldval_d;
  logic [1:0]       ldmask_q, ldmask_d;

  logic             req_c;
  logic             in_idle_c;
  logic             finish_c;
  logic [1:0]       al_off_c;
  logic [1:0]       al_size_c;
  logic [31:0]      al_sdata_c;
  logic [7:0]       lane_mask;
  logic             split;
  logic [31:0]      st_beat0;
  logic [31:0]      st_beat1;
  logic [31:0]      rd_raw;
  logic [31:0]      rd_ext;

  // In IDLE the first beat is set up straight from the request inputs.
  always_comb begin
    req_c      = is_load | is_store;
    in_idle_c  = (state_q == IDLE);
    al_off_c   = in_idle_c ? address[1:0]   : addr_q[1:0];
    al_size_c  = in_idle_c ? loadstore_size : size_q;
    al_sdata_c = in_idle_c ? store_data     : sdata_q;
  end

  lsu_lane_align u_align (
    .off         (al_off_c),
    .size        (al_size_c),
    .sign_ext    (sext_q),
    .st_data     (al_sdata_c),
    .rd_data     (wbm_dat_i),
    .rd_acc      (acc_q),
    .second_beat (state_q == BEAT1),
    .lane_mask   (lane_mask),
    .split       (split),
    .st_beat0    (st_beat0),
    .st_beat1    (st_beat1),
    .rd_raw      (rd_raw),
    .rd_ext      (rd_ext)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sext_d   = sext_q;
    dest_d   = dest_q;
    sdata_d  = sdata_q;
    store_d  = store_q;
    acc_d    = acc_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dato_d   = dato_q;
    ldv_d    = 1'b0;
    ldidx_d  = ldidx_q;
    ldval_d  = ldval_q;
    ldmask_d = ldmask_q;
    finish_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          addr_d  = address;
          size_d  = loadstore_size;
          sext_d  = sign_extend;
          dest_d  = loadstore_dest;
          sdata_d = store_data;
          store_d = is_store & ~is_load;
          acc_d   = 32'h0;
          state_d = BEAT0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = is_store & ~is_load;
          adr_d   = {address[31:2], 2'b00};
          sel_d   = lane_mask[3:0];
          dato_d  = st_beat0;
        end
      end
      BEAT0: begin
        if (wbm_ack_i) begin
          acc_d = rd_raw;
          if (split) begin
            state_d = BEAT1;
            adr_d   = {addr_q[31:2] + 30'd1, 2'b00};
            sel_d   = lane_mask[7:4];
            dato_d  = st_beat1;
          end else begin
            finish_c = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (wbm_ack_i) begin
          finish_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Last ack: release the bus and, for loads, post the register write.
    if (finish_c) begin
      state_d = DONE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = 4'h0;
      if (!store_q) begin
        ldv_d    = 1'b1;
        ldidx_d  = dest_q;
        ldval_d  = rd_ext;
        ldmask_d = 2'b11;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      dest_q   <= '0;
      sdata_q  <= 32'h0;
      store_q  <= 1'b0;
      acc_q    <= 32'h0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 32'h0;
      sel_q    <= 4'h0;
      dato_q   <= 32'h0;
      ldv_q    <= 1'b0;
      ldidx_q  <= '0;
      ldval_q  <= 32'h0;
      ldmask_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      dest_q   <= dest_d;
      sdata_q  <= sdata_d;
      store_q  <= store_d;
      acc_q    <= acc_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dato_q   <= dato_d;
      ldv_q    <= ldv_d;
      ldidx_q  <= ldidx_d;
      ldval_q  <= ldval_d;
      ldmask_q <= ldmask_d;
    end
  end

  // busy drops in DONE so the pipeline retires on that edge.
  assign busy = (in_idle_c & req_c) | (state_q == BEAT0) | (state_q == BEAT1);

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = sel_q;
  assign wbm_dat_o = dato_q;
  assign ld_valid  = ldv_q;
  assign ld_idx    = ldidx_q;
  assign ld_val    = ldval_q;
  assign ld_mask   = ldmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a zero/N-wait Wishbone responder.
module tb_load_store_unit;

  logic        wb_clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        is_load = 1'b0, is_store = 1'b0, sign_extend = 1'b0;
  logic [31:0] address = 32'h0, store_data = 32'h0, wbm_dat_i = 32'h0;
  logic [1:0]  loadstore_size = 2'd0;
  logic [5:0]  loadstore_dest = 6'd0;
  logic        wbm_ack_i = 1'b0;
  logic        busy, wbm_cyc_o, wbm_stb_o, wbm_we_o, ld_valid;
  logic [31:0] wbm_adr_o, wbm_dat_o, ld_val;
  logic [3:0]  wbm_sel_o;
  logic [5:0]  ld_idx;
  logic [1:0]  ld_mask;

  int vectors = 0;
  int miscompares = 0;

  // Observations from the most recent run_access call.
  logic        o_busy0, o_busy_at_ldv;
  int          o_nbeats, o_ldv_cnt, o_ldv_cyc, o_busy_last;
  int          o_cyc_first, o_cyc_last, o_cyc_cnt;
  logic [31:0] o_adr [2];
  logic [31:0] o_dat [2];
  logic [3:0]  o_sel [2];
  logic        o_we  [2];
  logic [31:0] o_ldval;
  logic [5:0]  o_ldidx;
  logic [1:0]  o_ldmask;

  load_store_unit #(.NUM_REGS(64)) dut (
    .wb_clk_i(wb_clk_i), .rst(rst), .is_load(is_load), .is_store(is_store),
    .address(address), .loadstore_size(loadstore_size), .sign_extend(sign_extend),
    .loadstore_dest(loadstore_dest), .store_data(store_data), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .ld_valid(ld_valid),
    .ld_idx(ld_idx), .ld_val(ld_val), .ld_mask(ld_mask)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Issue one request at a falling edge (cycle 0), then act as the slave for a
  // fixed 14-cycle window, recording beats and load write-backs.
  task automatic run_access(input logic ld, input logic st, input logic [31:0] a,
                            input logic [1:0] sz, input logic sx, input logic [5:0] dst,
                            input logic [31:0] sd, input logic [31:0] rd0,
                            input logic [31:0] rd1, input int waits);
    int wc;
    wc = 0;
    o_nbeats = 0; o_ldv_cnt = 0; o_ldv_cyc = -1; o_busy_last = -1; o_busy_at_ldv = 1'bx;
    o_cyc_first = -1; o_cyc_last = -1; o_cyc_cnt = 0;
    o_ldval = 32'hx; o_ldidx = 6'hx; o_ldmask = 2'bx;
    for (int i = 0; i < 2; i++) begin
      o_adr[i] = 32'hx; o_dat[i] = 32'hx; o_sel[i] = 4'hx; o_we[i] = 1'bx;
    end
    @(negedge wb_clk_i);
    is_load = ld; is_store = st; address = a; loadstore_size = sz;
    sign_extend = sx; loadstore_dest = dst; store_data = sd;
    #1 o_busy0 = busy;
    for (int n = 1; n <= 14; n++) begin
      @(negedge wb_clk_i);
      is_load = 1'b0; is_store = 1'b0;
      #1;
      if (busy) o_busy_last = n;
      if (wbm_cyc_o) begin
        if (o_cyc_cnt == 0) o_cyc_first = n;
        o_cyc_last = n;
        o_cyc_cnt++;
      end
      if (ld_valid) begin
        o_ldv_cnt++; o_ldv_cyc = n; o_ldval = ld_val; o_ldidx = ld_idx;
        o_ldmask = ld_mask; o_busy_at_ldv = busy;
      end
      if (wbm_stb_o && wc == waits) begin
        if (o_nbeats < 2) begin
          o_adr[o_nbeats] = wbm_adr_o; o_sel[o_nbeats] = wbm_sel_o;
          o_dat[o_nbeats] = wbm_dat_o; o_we[o_nbeats] = wbm_we_o;
        end
        wbm_dat_i = (o_nbeats == 0) ? rd0 : rd1;
        wbm_ack_i = 1'b1;
        o_nbeats++;
        wc = 0;
      end else begin
        wbm_ack_i = 1'b0;
        if (wbm_stb_o) wc++;
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    #1;
    vectors++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl got cyc=%b stb=%b we=%b want 000", wbm_cyc_o, wbm_stb_o, wbm_we_o); end
    vectors++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin miscompares++; $display("FAIL reset_bus got adr=%h dat=%h sel=%h want zeros", wbm_adr_o, wbm_dat_o, wbm_sel_o); end
    vectors++; if (ld_valid !== 1'b0 || ld_idx !== 6'd0 || ld_val !== 32'h0 || ld_mask !== 2'b00) begin miscompares++; $display("FAIL reset_ld got v=%b idx=%0d val=%h mask=%b want zeros", ld_valid, ld_idx, ld_val, ld_mask); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_aligned_word();
    run_access(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 6'd5, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    vectors++; if (o_busy0 !== 1'b1) begin miscompares++; $display("FAIL word_busy0 got %b want 1", o_busy0); end
    vectors++; if (o_nbeats !== 1) begin miscompares++; $display("FAIL word_beats got %0d want 1", o_nbeats); end
    vectors++; if (o_adr[0] !== 32'h100 || o_sel[0] !== 4'hF || o_we[0] !== 1'b0) begin miscompares++; $display("FAIL word_beat0 got adr=%h sel=%h we=%b want 100/F/0", o_adr[0], o_sel[0], o_we[0]); end
    vectors++; if (o_ldv_cnt !== 1 || o_ldv_cyc !== 2) begin miscompares++; $display("FAIL word_ldv_timing got cnt=%0d cyc=%0d want 1/2", o_ldv_cnt, o_ldv_cyc); end
    vectors++; if (o_ldval !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_ldval got %h want deadbeef", o_ldval); end
    vectors++; if (o_ldidx !== 6'd5 || o_ldmask !== 2'b11) begin miscompares++; $display("FAIL word_ldidx got idx=%0d mask=%b want 5/11", o_ldidx, o_ldmask); end
    vectors++; if (o_busy_last !== 1 || o_busy_at_ldv !== 1'b0) begin miscompares++; $display("FAIL word_busy got last=%0d at_ldv=%b want 1/0", o_busy_last, o_busy_at_ldv); end
  endtask

  task automatic test_byte_sign();
    run_access(1'b1, 1'b0, 32'h203, 2'd0, 1'b1, 6'd9, 32'h0, 32'h80FFFFFF, 32'h0, 0);
    vectors++; if (o_adr[0] !== 32'h200 || o_sel[0] !== 4'h8 || o_nbeats !== 1) begin miscompares++; $display("FAIL sbyte_beat got adr=%h sel=%h beats=%0d want 200/8/1", o_adr[0], o_sel[0], o_nbeats); end
    vectors++; if (o_ldval !== 32'hFFFFFF80) begin miscompares++; $display("FAIL sbyte_ldval got %h want ffffff80", o_ldval); end
    run_access(1'b1, 1'b0, 32'h203, 2'd0, 1'b0, 6'd9, 32'h0, 32'h80FFFFFF, 32'h0, 0);
    vectors++; if (o_ldval !== 32'h00000080) begin miscompares++; $display("FAIL ubyte_ldval got %h want 00000080", o_ldval); end
  endtask

  task automatic test_misaligned_store();
    run_access(1'b0, 1'b1, 32'h301, 2'd2, 1'b0, 6'd3, 32'h11223344, 32'h0, 32'h0, 0);
    vectors++; if (o_nbeats !== 2) begin miscompares++; $display("FAIL mstore_beats got %0d want 2", o_nbeats); end
    vectors++; if (o_adr[0] !== 32'h300 || o_sel[0] !== 4'hE || o_dat[0] !== 32'h22334400 || o_we[0] !== 1'b1) begin miscompares++; $display("FAIL mstore_beat0 got adr=%h sel=%h dat=%h we=%b want 300/E/22334400/1", o_adr[0], o_sel[0], o_dat[0], o_we[0]); end
    vectors++; if (o_adr[1] !== 32'h304 || o_sel[1] !== 4'h1 || o_dat[1][7:0] !== 8'h11 || o_we[1] !== 1'b1) begin miscompares++; $display("FAIL mstore_beat1 got adr=%h sel=%h dat=%h we=%b want 304/1/xx11/1", o_adr[1], o_sel[1], o_dat[1], o_we[1]); end
    vectors++; if (o_cyc_cnt !== 2 || o_cyc_first !== 1 || o_cyc_last !== 2) begin miscompares++; $display("FAIL mstore_cyc got cnt=%0d first=%0d last=%0d want 2/1/2", o_cyc_cnt, o_cyc_first, o_cyc_last); end
    vectors++; if (o_ldv_cnt !== 0) begin miscompares++; $display("FAIL mstore_noldv got %0d want 0", o_ldv_cnt); end
    vectors++; if (o_busy_last !== 2) begin miscompares++; $display("FAIL mstore_busy got last=%0d want 2", o_busy_last); end
  endtask

  task automatic test_half_split();
    run_access(1'b1, 1'b0, 32'h403, 2'd1, 1'b1, 6'd12, 32'h0, 32'hAB000000, 32'h000000CD, 0);
    vectors++; if (o_adr[0] !== 32'h400 || o_sel[0] !== 4'h8 || o_adr[1] !== 32'h404 || o_sel[1] !== 4'h1) begin miscompares++; $display("FAIL half_beats got %h/%h %h/%h want 400/8 404/1", o_adr[0], o_sel[0], o_adr[1], o_sel[1]); end
    vectors++; if (o_ldval !== 32'hFFFFCDAB || o_ldv_cyc !== 3) begin miscompares++; $display("FAIL half_ldval got %h cyc=%0d want ffffcdab/3", o_ldval, o_ldv_cyc); end
  endtask

  task automatic test_wrap();
    run_access(1'b1, 1'b0, 32'hFFFFFFFE, 2'd2, 1'b1, 6'd1, 32'h0, 32'hBBAA0000, 32'h0000DDCC, 0);
    vectors++; if (o_adr[0] !== 32'hFFFFFFFC || o_sel[0] !== 4'hC) begin miscompares++; $display("FAIL wrap_beat0 got adr=%h sel=%h want fffffffc/C", o_adr[0], o_sel[0]); end
    vectors++; if (o_adr[1] !== 32'h0 || o_sel[1] !== 4'h3) begin miscompares++; $display("FAIL wrap_beat1 got adr=%h sel=%h want 0/3", o_adr[1], o_sel[1]); end
    vectors++; if (o_ldval !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL wrap_ldval got %h want ddccbbaa", o_ldval); end
  endtask

  task automatic test_wait_states();
    run_access(1'b1, 1'b0, 32'h500, 2'd3, 1'b1, 6'd63, 32'h0, 32'h82345678, 32'h0, 2);
    vectors++; if (o_ldv_cyc !== 4 || o_busy_last !== 3) begin miscompares++; $display("FAIL wait_timing got ldv=%0d busy_last=%0d want 4/3", o_ldv_cyc, o_busy_last); end
    vectors++; if (o_ldval !== 32'h82345678 || o_ldidx !== 6'd63) begin miscompares++; $display("FAIL wait_ldval got %h idx=%0d want 82345678/63", o_ldval, o_ldidx); end
  endtask

  task automatic test_both_high();
    run_access(1'b1, 1'b1, 32'h600, 2'd0, 1'b0, 6'd20, 32'h55555555, 32'hFFFFFFA5, 32'h0, 0);
    vectors++; if (o_we[0] !== 1'b0 || o_sel[0] !== 4'h1) begin miscompares++; $display("FAIL both_beat got we=%b sel=%h want 0/1", o_we[0], o_sel[0]); end
    vectors++; if (o_ldv_cnt !== 1 || o_ldval !== 32'h000000A5 || o_ldidx !== 6'd20) begin miscompares++; $display("FAIL both_ld got cnt=%0d val=%h idx=%0d want 1/a5/20", o_ldv_cnt, o_ldval, o_ldidx); end
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h12345678;
    for (int n = 0; n < 3; n++) begin
      @(negedge wb_clk_i);
      #1 if (wbm_cyc_o || ld_valid || busy) bad++;
    end
    wbm_ack_i = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stray_ack got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_midflight();
    int bad;
    bad = 0;
    @(negedge wb_clk_i);
    is_load = 1'b1; address = 32'h800; loadstore_size = 2'd2; loadstore_dest = 6'd4;
    @(negedge wb_clk_i);
    is_load = 1'b0; wbm_ack_i = 1'b0;
    #1;
    vectors++; if (wbm_stb_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat0 got stb=%b want 1", wbm_stb_o); end
    rst = 1'b1;
    @(negedge wb_clk_i);
    #1;
    vectors++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || ld_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_drop got cyc=%b stb=%b ldv=%b busy=%b want 0000", wbm_cyc_o, wbm_stb_o, ld_valid, busy); end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge wb_clk_i);
      #1 if (wbm_cyc_o || ld_valid) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); end
    run_access(1'b1, 1'b0, 32'h900, 2'd2, 1'b0, 6'd7, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    vectors++; if (o_ldval !== 32'hCAFEF00D || o_ldv_cyc !== 2 || o_ldidx !== 6'd7) begin miscompares++; $display("FAIL rstmid_after got %h cyc=%0d idx=%0d want cafef00d/2/7", o_ldval, o_ldv_cyc, o_ldidx); end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_byte_sign();
    test_misaligned_store();
    test_half_split();
    test_wrap();
    test_wait_states();
    test_both_high();
    test_stray_ack();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
